sram_1r1w_macro_model: RTL and testbench

Cycle-accurate behavioural model of the sky130 1R1W SRAM macro. It is the responder end of the csb/wmask/addr/din/dout macro interface that the block-RAM mapping wrappers drive. It is used in RTL simulation and FPGA builds in place of the hard macro.
- Write port (port 0) supports byte-lane masking.
- Read port (port 1) has one-cycle registered read latency.
- An optional post-reset clear sequencer zeroes the array.

---
 rtl/sram_1r1w_macro_model.sv | 150 +++++++++++++++
 tb/tb_sram_1r1w_macro_model.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_macro_model.sv
// Behavioural model of the sky130 1R1W SRAM macro: masked write port 0, registered read port 1.
// Optional write-first collision forwarding is enabled with `define SRAM_MODEL_WRITE_FIRST_EN.
module sram_1r1w_macro_model #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BYTE       = 8,
  parameter int INIT_CLEAR = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    csb0,
  input  logic [WIDTH/BYTE-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [WIDTH-1:0]        din0,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [WIDTH-1:0]        dout1,
  output logic                    busy,
  output logic                    collision
);

  localparam int LANES = WIDTH / BYTE;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam state_e RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]      dout1_q, dout1_d;
  logic                  collision_q, collision_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic [LANES-1:0]      mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      rd_word;
  logic                  hit;
  logic                  in_range0;
  logic                  in_range1;

  // Addresses can only fall outside the array when DEPTH is not a power of two.
  generate
    if ((1 << ADDR_WIDTH) == DEPTH) begin : g_pow2
      assign in_range0 = 1'b1;
      assign in_range1 = 1'b1;
    end else begin : g_npow2
      localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
      assign in_range0 = {1'b0, addr0} < DEPTH_EXT;
      assign in_range1 = {1'b0, addr1} < DEPTH_EXT;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dout1_d     = dout1_q;
    collision_d = 1'b0;
    mem_we      = '0;
    mem_waddr   = ptr_q;
    mem_wdata   = '0;
    rd_word     = '0;
    hit         = 1'b0;

    case (state_q)
      CLEAR: begin
        dout1_d   = '0;
        mem_we    = '1;
        mem_waddr = ptr_q;
        if (ptr_q == LAST_PTR) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      READY: begin
        hit = !csb0 && !csb1 && in_range1 && (addr0 == addr1) && (|wmask0);
        collision_d = hit;

        if (!csb0 && in_range0) begin
          mem_we    = wmask0;
          mem_waddr = addr0;
          mem_wdata = din0;
        end

        if (!csb1) begin
          if (in_range1) begin
            rd_word = mem_q[addr1];
`ifdef SRAM_MODEL_WRITE_FIRST_EN
            // Collided lanes forward the incoming write data.
            if (hit) begin
              for (int i = 0; i < LANES; i++) begin
                if (wmask0[i]) begin
                  rd_word[i*BYTE +: BYTE] = din0[i*BYTE +: BYTE];
                end
              end
            end
`endif
            dout1_d = rd_word;
          end else begin
            dout1_d = '0;
          end
        end
      end

      default: begin
        state_d = READY;
      end
    endcase

    // The array must not change while reset is held.
    if (!rst_n) begin
      mem_we = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      ptr_q       <= '0;
      dout1_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dout1_q     <= dout1_d;
      collision_q <= collision_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we[i]) begin
        mem_q[mem_waddr][i*BYTE +: BYTE] <= mem_wdata[i*BYTE +: BYTE];
      end
    end
  end

  assign dout1     = dout1_q;
  assign collision = collision_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_sram_1r1w_macro_model.sv
// Self-checking bench for sram_1r1w_macro_model (DEPTH=64, INIT_CLEAR=1).
// Compile with +define+SRAM_MODEL_WRITE_FIRST_EN to check the write-first build.
module tb_sram_1r1w_macro_model;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LANES = 4;

`ifdef SRAM_MODEL_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             csb0 = 1'b1;
  logic [LANES-1:0] wmask0 = '0;
  logic [AW-1:0]    addr0 = '0;
  logic [WIDTH-1:0] din0 = '0;
  logic             csb1 = 1'b1;
  logic [AW-1:0]    addr1 = '0;
  logic [WIDTH-1:0] dout1;
  logic             busy;
  logic             collision;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_busy;

  sram_1r1w_macro_model #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BYTE(8), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1), .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  // Reference model: a plain word array, a countdown of remaining clear cycles,
  // and the expected registered outputs.
  logic [WIDTH-1:0] mdl_mem [DEPTH];
  int               clear_left;
  logic [WIDTH-1:0] exp_dout;
  logic             exp_coll;
  wire              exp_busy = (clear_left > 0);
  wire              mdl_hit  = !csb0 && !csb1 && (addr0 == addr1) && (wmask0 != '0);

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] res;
    for (int b = 0; b < LANES; b++)
      res[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return res;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_left <= DEPTH;
      exp_dout   <= '0;
      exp_coll   <= 1'b0;
    end else if (clear_left > 0) begin
      mdl_mem[DEPTH - clear_left] <= '0;
      clear_left <= clear_left - 1;
      exp_coll   <= 1'b0;
    end else begin
      exp_coll <= mdl_hit;
      if (!csb1)
        exp_dout <= (WRITE_FIRST && mdl_hit) ? lane_merge(mdl_mem[addr1], din0, wmask0)
                                             : mdl_mem[addr1];
      if (!csb0)
        mdl_mem[addr0] <= lane_merge(mdl_mem[addr0], din0, wmask0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Every cycle, compare all outputs against the model once they have settled.
  always @(negedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      checkOutput("mdl_busy", {31'b0, busy}, {31'b0, exp_busy});
      checkOutput("mdl_collision", {31'b0, collision}, {31'b0, exp_coll});
      checkOutput("mdl_dout1", dout1, exp_dout);
    end
  end

  // Drive one cycle of port activity and return at the following falling edge.
  task automatic applyStimulus(input logic c0, input logic [LANES-1:0] m0,
                               input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                               input logic c1, input logic [AW-1:0] a1);
    csb0 = c0; wmask0 = m0; addr0 = a0; din0 = d0;
    csb1 = c1; addr1 = a1;
    @(negedge clk);
  endtask

  task automatic set_idle();
    csb0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
  endtask

  // Count falling edges with busy high after release; optionally inject port
  // traffic or re-assert reset at a given clear cycle. Bounded at 200 cycles.
  task automatic count_busy(input int inject_at, input int reset_at, output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      n++;
      if (c == reset_at) begin
        rst_n = 1'b0;
        break;
      end
      if (inject_at >= 0 && c == inject_at + 1)
        checkOutput("clear_dout_hold", dout1, 32'h0);
      if (c == inject_at) begin
        csb0 = 1'b0; wmask0 = 4'hF; addr0 = 6'd3; din0 = 32'hFFFF_FFFF;
        csb1 = 1'b0; addr1 = 6'd3;
      end else begin
        set_idle();
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, AW'(a));
      checkOutput("read_zero", dout1, 32'h0);
      checkOutput("read_zero_coll", {31'b0, collision}, 32'h0);
    end
    set_idle();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    checkOutput("rst_busy", {31'b0, busy}, 32'h1);
    checkOutput("rst_dout1", dout1, 32'h0);
    checkOutput("rst_collision", {31'b0, collision}, 32'h0);

    // Clear sequence with ignored traffic at clear cycle 10
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_busy(10, -1, n_busy);
    checkOutput("busy_cycles", 32'(n_busy), 32'd64);
    read_all_zero();

    // Full write then read, then hold
    applyStimulus(1'b0, 4'hF, 6'd5, 32'hDEAD_BEEF, 1'b1, 6'd0);
    applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd5);
    checkOutput("rd_full", dout1, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd9);
    applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd9);
    checkOutput("rd_hold", dout1, 32'hDEAD_BEEF);

    // Partial lane write
    applyStimulus(1'b0, 4'b0101, 6'd5, 32'h1122_3344, 1'b1, 6'd0);
    applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd5);
    checkOutput("rd_masked", dout1, 32'hDE22_BE44);

    // Collision on address 7
    applyStimulus(1'b0, 4'hF, 6'd7, 32'hAAAA_5555, 1'b1, 6'd0);
    applyStimulus(1'b0, 4'b0011, 6'd7, 32'h1234_5678, 1'b0, 6'd7);
    checkOutput("coll_flag", {31'b0, collision}, 32'h1);
    checkOutput("coll_dout", dout1, WRITE_FIRST ? 32'hAAAA_5678 : 32'hAAAA_5555);
    applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0);
    checkOutput("coll_pulse_end", {31'b0, collision}, 32'h0);
    applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd7);
    checkOutput("coll_after", dout1, 32'hAAAA_5678);

    // Zero-mask write to the read address is neither a write nor a collision
    applyStimulus(1'b0, 4'h0, 6'd7, 32'h0, 1'b0, 6'd7);
    checkOutput("nomask_coll", {31'b0, collision}, 32'h0);
    checkOutput("nomask_dout", dout1, 32'hAAAA_5678);

    // Back-to-back: write each cycle, read the previous address each cycle
    applyStimulus(1'b0, 4'hF, 6'd10, 32'h0000_00A0, 1'b1, 6'd0);
    applyStimulus(1'b0, 4'hF, 6'd11, 32'h0000_00B1, 1'b0, 6'd10);
    checkOutput("b2b_0", dout1, 32'h0000_00A0);
    applyStimulus(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd11);
    checkOutput("b2b_1", dout1, 32'h0000_00B1);
    set_idle();

    // Reset at clear cycle 20, then a full clear after the second release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(-1, 20, n_busy);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy(-1, -1, n_busy);
    checkOutput("busy_cycles_restart", 32'(n_busy), 32'd64);
    read_all_zero();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
